muldiv_seq: RTL

Multi-cycle sequencer for the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It replaces single-cycle combinational multiply/divide with one shared 32-iteration shift-add / restoring-divide engine. It sits beside the integer ALU in execute. The pipeline issues an M-type op with a start pulse, stalls on `busy`, and captures `result` when `done` pulses.

---
 rtl/muldiv_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: one shared 32-iteration shift-add /
// restoring-divide engine, with divide-by-zero and overflow short-circuited.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              special_q, special_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              accept;
    logic              a_signed, b_signed, neg_a, neg_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_val;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

    assign accept   = (state_q == S_IDLE) && start_i && !kill_i;

    // Operand decode at acceptance: sign flags, magnitudes, short-circuit detection
    assign a_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign b_signed = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign neg_a    = a_signed && a_i[XLEN-1];
    assign neg_b    = b_signed && b_i[XLEN-1];
    assign mag_a    = neg_a ? -a_i : a_i;
    assign mag_b    = neg_b ? -b_i : b_i;
    assign div_zero = funct3_i[2] && (b_i == '0);
    assign div_ovf  = funct3_i[2] && !funct3_i[0] &&
                      (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    assign special_val = div_zero ? (funct3_i[1] ? a_i : '1)
                                  : (funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // Multiply: acc holds {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc holds {remainder, quotient}; the shifted remainder needs one extra bit
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign rem_ge   = rem_sh >= {1'b0, opnd_q};
    assign rem_diff = rem_sh[XLEN-1:0] - opnd_q;
    assign div_next = rem_ge ? {rem_diff, acc_q[XLEN-2:0], 1'b1}
                             : {acc_q[2*XLEN-2:0], 1'b0};

    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_val = rem_fix;
        if (special_q) begin
            fix_val = acc_q[XLEN-1:0];
        end else begin
            unique case (op_q)
                3'b000:                 fix_val = prod_fix[XLEN-1:0];
                3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
                3'b100, 3'b101:         fix_val = quot_fix;
                default:                fix_val = rem_fix;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            special_q <= 1'b0;
            done_q    <= 1'b0;
            opnd_q    <= '0;
            result_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            special_q <= special_d;
            done_q    <= done_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (kill_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (start_i) state_d = (div_zero || div_ovf) ? S_FIX : S_CALC;
                S_CALC: if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
                S_FIX:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        special_d = special_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = funct3_i;
                    neg_a_d   = neg_a;
                    neg_b_d   = neg_b;
                    special_d = div_zero || div_ovf;
                    cnt_d     = '0;
                    if (funct3_i[2]) begin
                        opnd_d = mag_b;
                        acc_d  = {{XLEN{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{XLEN{1'b0}}, mag_b};
                    end
                    if (div_zero || div_ovf) acc_d = {{XLEN{1'b0}}, special_val};
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
            end
            S_FIX: begin
                if (!kill_i) begin
                    result_d = fix_val;
                    done_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
